spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), 16-bit frames, MSB first.
// SS setup/hold/gap timing and the SCLK half-period are set in sysClk cycles.
module spi_master #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned SS_SETUP = 4,
  parameter int unsigned SS_HOLD  = 4,
  parameter int unsigned SS_GAP   = 4
) (
  input  logic        sysClk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SS_SETUP - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(SS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(SS_GAP - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  bit_cnt, bit_n;
  logic [15:0] shift, shift_n, rx_n;
  logic        sclk_n, mosi_n, ss_n, busy_n, done_n;
  logic        miso_meta, miso_s;

  always_ff @(posedge sysClk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rx      <= '0;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
      SS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      rx      <= rx_n;
      SCLK    <= sclk_n;
      MOSI    <= mosi_n;
      SS      <= ss_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    bit_n   = bit_cnt;
    shift_n = shift;
    rx_n    = rx;
    sclk_n  = SCLK;
    mosi_n  = MOSI;
    ss_n    = SS;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        sclk_n = 1'b1;
        if (start) begin
          shift_n = tx;
          ss_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          sclk_n  = 1'b0;
          mosi_n  = shift[15];
          state_n = LOW;
        end
      end
      LOW: begin
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          sclk_n  = 1'b1;
          shift_n = {shift[14:0], miso_s};
          bit_n   = bit_cnt + 4'd1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          // bit counter has wrapped to 0 only after the 16th rising edge
          if (bit_cnt == 4'd0) begin
            state_n = HOLD;
          end else begin
            sclk_n  = 1'b0;
            mosi_n  = shift[15];
            state_n = LOW;
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          ss_n    = 1'b1;
          rx_n    = shift;
          done_n  = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
